// File: rtl/stream_wrr_scheduler.sv
// Packet-granular weighted round-robin scheduler: N stream inputs share one output, and each
// grant lasts for s_qos_i+1 beats of credit. A packet is always allowed to finish.
module stream_wrr_scheduler #(
    parameter int STREAM_COUNT = 2,
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int T_ID___WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT],
    input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT],
    input  logic [STREAM_COUNT-1:0] s_last_i,
    input  logic [STREAM_COUNT-1:0] s_valid_i,
    output logic [STREAM_COUNT-1:0] s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_QOS__WIDTH-1:0] m_qos_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [T_ID___WIDTH-1:0] m_id_o
);
    localparam int CW = T_QOS__WIDTH + 1;
    localparam logic [0:0] ST_SELECT = 1'b0;
    localparam logic [0:0] ST_XFER   = 1'b1;

    logic [0:0]              state_reg,  state_next;
    logic [T_ID___WIDTH-1:0] grant_reg,  grant_next;
    logic [T_ID___WIDTH-1:0] ptr_reg,    ptr_next;
    logic [CW-1:0]           credit_reg, credit_next;
    logic                    fresh_reg,  fresh_next;

    logic                    in_xfer;
    logic                    accept;
    logic                    scan_found;
    logic [T_ID___WIDTH-1:0] scan_idx;
    int                      scan_start;
    int                      scan_pos;
    int                      best_pos;

    assign in_xfer   = (state_reg == ST_XFER);
    assign m_valid_o = in_xfer & s_valid_i[grant_reg];
    assign m_data_o  = in_xfer ? s_data_i[grant_reg] : '0;
    assign m_qos_o   = in_xfer ? s_qos_i[grant_reg]  : '0;
    assign m_last_o  = in_xfer & s_last_i[grant_reg];
    assign m_id_o    = grant_reg;
    assign accept    = m_valid_o & m_ready_i;

    generate
        for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_ready
            assign s_ready_o[gi] = in_xfer && m_ready_i && (grant_reg == T_ID___WIDTH'(gi));
        end
    endgenerate

    // Round-robin search: the valid stream closest after ptr wins; right after reset the
    // search begins at stream 0 so the very first grant is deterministic.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_pos   = 0;
        best_pos   = STREAM_COUNT;
        if (fresh_reg || (int'(ptr_reg) + 1 >= STREAM_COUNT)) begin
            scan_start = 0;
        end else begin
            scan_start = int'(ptr_reg) + 1;
        end
        for (int k = 0; k < STREAM_COUNT; k++) begin
            scan_pos = k - scan_start;
            if (scan_pos < 0) begin
                scan_pos = scan_pos + STREAM_COUNT;
            end
            if (s_valid_i[k] && (scan_pos < best_pos)) begin
                best_pos   = scan_pos;
                scan_idx   = T_ID___WIDTH'(k);
                scan_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ptr_next    = ptr_reg;
        credit_next = credit_reg;
        fresh_next  = fresh_reg;
        if (state_reg == ST_SELECT) begin
            if ((credit_reg != '0) && s_valid_i[grant_reg]) begin
                state_next = ST_XFER;
            end else if (scan_found) begin
                grant_next  = scan_idx;
                ptr_next    = scan_idx;
                credit_next = CW'(s_qos_i[scan_idx]) + CW'(1);
                fresh_next  = 1'b0;
                state_next  = ST_XFER;
            end
        end else if (accept) begin
            // Credit saturates so an over-long packet can finish without borrowing from the next round.
            if (credit_reg != '0) begin
                credit_next = credit_reg - CW'(1);
            end
            if (m_last_o) begin
                state_next = ST_SELECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_SELECT;
            grant_reg  <= '0;
            ptr_reg    <= '0;
            credit_reg <= '0;
            fresh_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            credit_reg <= credit_next;
            fresh_reg  <= fresh_next;
        end
    end
endmodule

// File: tb/tb_stream_wrr_scheduler.sv
// Randomized bench for stream_wrr_scheduler: packet-level reference model feeds an expected-beat
// scoreboard; a separate monitor pops and compares every accepted output beat.
module tb_stream_wrr_scheduler;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int QW = 4;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data_i [N];
    logic [QW-1:0] s_qos_i  [N];
    logic [N-1:0]  s_last_i;
    logic [N-1:0]  s_valid_i;
    logic [N-1:0]  s_ready_o;
    logic [DW-1:0] m_data_o;
    logic [QW-1:0] m_qos_o;
    logic          m_last_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [IW-1:0] m_id_o;

    always #5 clk = ~clk;

    stream_wrr_scheduler #(
        .STREAM_COUNT(N), .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .T_ID___WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_last_o(m_last_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_id_o(m_id_o)
    );

    typedef struct {
        int id;
        int data;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Source side: each stream owns at most one packet of 1..4 beats at a time.
    int       pkt_len [N];
    int       pkt_idx [N];
    logic [7:0] pkt_data [N][4];
    bit       busy [N];
    bit       hold [N];

    // Reference model: packet-level WRR bookkeeping.
    int m_state;   // 0 = choosing the next packet, 1 = packet in flight
    int m_grant;
    int m_ptr;
    int m_credit;
    bit m_fresh;
    bit mid_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic new_packet(input int s);
        pkt_len[s] = $urandom_range(1, 4);
        for (int b = 0; b < 4; b++) pkt_data[s][b] = 8'($urandom);
        pkt_idx[s] = 0;
        busy[s]    = 1'b1;
    endtask

    task automatic drive(input bit force_new);
        for (int s = 0; s < N; s++) begin
            if (!busy[s] && (force_new || $urandom_range(0, 3) == 0)) new_packet(s);
            if ($urandom_range(0, 15) == 0) s_qos_i[s] = 4'($urandom_range(0, 15));
            if (busy[s]) begin
                if (pkt_idx[s] == 0 || hold[s]) s_valid_i[s] = 1'b1;
                else                            s_valid_i[s] = ($urandom_range(0, 3) != 0);
                s_data_i[s] = pkt_data[s][pkt_idx[s]];
                s_last_i[s] = (pkt_idx[s] == pkt_len[s] - 1);
            end else begin
                s_valid_i[s] = 1'b0;
                s_data_i[s]  = 8'($urandom);
                s_last_i[s]  = 1'b0;
            end
        end
        m_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid_o), 0);
        chk({tag, "_s_ready"}, 32'(s_ready_o), 0);
        chk({tag, "_m_last"},  32'(m_last_o),  0);
        chk({tag, "_m_id"},    32'(m_id_o),    0);
    endtask

    // Assert reset at the current time, check outputs drop at once, hold 3 cycles with all
    // streams valid, then release and give every stream a fresh packet.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_idle("rst_now");
        exp_q.delete();
        m_state = 0; m_grant = 0; m_ptr = 0; m_credit = 0; m_fresh = 1'b1;
        for (int s = 0; s < N; s++) begin
            busy[s] = 1'b0;
            hold[s] = 1'b0;
        end
        s_valid_i = '1;
        repeat (3) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1);
    endtask

    task automatic step();
        logic [N-1:0] v;
        logic         r;
        int           k;
        int           c;
        int           start;
        v = s_valid_i;
        r = m_ready_i;
        if (m_state == 0) begin
            chk("sel_m_valid", 32'(m_valid_o), 0);
            chk("sel_s_ready", 32'(s_ready_o), 0);
            chk("sel_m_id",    32'(m_id_o),    m_grant);
            k = -1;
            if (m_credit > 0 && v[m_grant]) begin
                k = m_grant;
            end else begin
                start = m_fresh ? 0 : (m_ptr + 1) % N;
                for (int i = 0; i < N; i++) begin
                    c = (start + i) % N;
                    if (k < 0 && v[c]) k = c;
                end
                if (k >= 0) begin
                    m_grant  = k;
                    m_ptr    = k;
                    m_credit = int'(s_qos_i[k]) + 1;
                    m_fresh  = 1'b0;
                end
            end
            if (k >= 0) begin
                for (int b = 0; b < pkt_len[k]; b++) begin
                    exp_q.push_back('{id: k, data: int'(pkt_data[k][b]), last: int'(b == pkt_len[k] - 1)});
                end
                m_state = 1;
            end
        end else begin
            chk("xfer_m_valid", 32'(m_valid_o), 32'(v[m_grant]));
            chk("xfer_s_ready", 32'(s_ready_o), r ? (1 << m_grant) : 0);
            chk("xfer_m_id",    32'(m_id_o),    m_grant);
            if (v[m_grant]) chk("xfer_m_qos", 32'(m_qos_o), 32'(s_qos_i[m_grant]));
            if (v[m_grant] && r) begin
                if (m_credit > 0) m_credit--;
                if (s_last_i[m_grant]) m_state = 0;
            end
        end
        for (int s = 0; s < N; s++) begin
            hold[s] = v[s] && !s_ready_o[s];
            if (v[s] && s_ready_o[s]) begin
                if (pkt_idx[s] == pkt_len[s] - 1) busy[s] = 1'b0;
                else                             pkt_idx[s]++;
            end
        end
    endtask

    // Scoreboard monitor: every accepted beat must be the next one the model expects.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got id %0d data %0h, expected no beat", m_id_o, m_data_o);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_id",   32'(m_id_o),   e.id);
                chk("beat_data", 32'(m_data_o), e.data);
                chk("beat_last", 32'(m_last_o), e.last);
            end
        end
    end

    initial begin
        for (int s = 0; s < N; s++) begin
            s_data_i[s] = '0;
            s_qos_i[s]  = 4'($urandom_range(0, 15));
            busy[s]     = 1'b0;
            hold[s]     = 1'b0;
            pkt_len[s]  = 1;
            pkt_idx[s]  = 0;
        end
        s_last_i  = '0;
        s_valid_i = '0;
        m_ready_i = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            step();
            @(posedge clk);
            #1;
            if (cyc > 1500 && !mid_done && m_state == 1 && busy[m_grant] && pkt_idx[m_grant] > 0) begin
                drive(1'b0);
                #2;
                mid_done = 1'b1;
                do_reset();
            end else begin
                drive(1'b0);
            end
        end
        chk("mid_packet_reset_seen", 32'(mid_done), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
